// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Iteration counter width; the counter only ever holds WIDTH-1 down to 0.
  function automatic int unsigned div_cnt_width(input int unsigned width);
    return $clog2(width);
  endfunction

  localparam int unsigned DIV_CNT_W_DEFAULT = div_cnt_width(DIV_WIDTH_DEFAULT);

endpackage

// File: rtl/div_trial_sub.sv
// Combinational trial subtractor: ripple chain of full-adder cells computing
// minuend + ~subtrahend + 1, with borrow taken from the final carry.
module div_trial_sub #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] minuend_i,
  input  logic [W-1:0] subtrahend_i,
  output logic [W-1:0] diff_o,
  output logic         borrow_o
);

  logic [W:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_fa
    logic sub_inv;
    assign sub_inv      = ~subtrahend_i[i];
    assign diff_o[i]    = minuend_i[i] ^ sub_inv ^ carry[i];
    assign carry[i+1]   = (minuend_i[i] & sub_inv) | (carry[i] & (minuend_i[i] ^ sub_inv));
  end

  // No carry out of the top means the subtraction wrapped.
  assign borrow_o = ~carry[W];

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock with a
// start/busy/done handshake; q, r and div_by_zero hold until the next completion.
module restoring_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = div_cnt_width(WIDTH);
  localparam int unsigned TW    = WIDTH + 1;

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] qsr_q, qsr_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, done_q;

  logic [TW-1:0]    trial_min_c;
  logic [TW-1:0]    trial_diff_c;
  logic             trial_borrow_c;
  logic             restore_c;

  assign trial_min_c = {prem_q, qsr_q[WIDTH-1]};

  div_trial_sub #(
    .W (TW)
  ) u_trial (
    .minuend_i    (trial_min_c),
    .subtrahend_i ({1'b0, b_q}),
    .diff_o       (trial_diff_c),
    .borrow_o     (trial_borrow_c)
  );

  // Trial MSB and borrow agree whenever the partial remainder is below the divisor.
  assign restore_c = trial_borrow_c | trial_diff_c[WIDTH];

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    prem_d  = prem_q;
    qsr_d   = qsr_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;

    case (state_q)
      RUN: begin
        prem_d = restore_c ? trial_min_c[WIDTH-1:0] : trial_diff_c[WIDTH-1:0];
        qsr_d  = {qsr_q[WIDTH-2:0], ~restore_c};
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
          q_d     = qsr_d;
          r_d     = prem_d;
          dbz_d   = 1'b0;
        end
      end
      default: begin
        if (start) begin
          qsr_d  = a;
          b_d    = b;
          prem_d = '0;
          cnt_d  = CNT_W'(WIDTH - 1);
          if (b == '0) begin
            state_d = DONE;
            q_d     = '1;
            r_d     = a;
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prem_q  <= '0;
      qsr_q   <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prem_q  <= prem_d;
      qsr_q   <= qsr_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign q           = q_q;
  assign r           = r_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: arithmetic reference model with a
// per-cycle compare, plus directed vectors with hand-computed results.
module tb_restoring_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] q, r;

  int n_tests = 0;
  int n_fail  = 0;

  restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .q           (q),
    .r           (r),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: cycles remaining until completion plus the pending result.
  int           m_left = 0;
  logic         exp_busy = 1'b0, exp_done = 1'b0, exp_dbz = 1'b0;
  logic [W-1:0] exp_q = '0, exp_r = '0;
  logic [W-1:0] pend_q = '0, pend_r = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left   <= 0;
      exp_busy <= 1'b0;
      exp_done <= 1'b0;
      exp_dbz  <= 1'b0;
      exp_q    <= '0;
      exp_r    <= '0;
    end else if (m_left > 0) begin
      m_left   <= m_left - 1;
      exp_done <= 1'b0;
      if (m_left == 1) begin
        exp_busy <= 1'b0;
        exp_done <= 1'b1;
        exp_q    <= pend_q;
        exp_r    <= pend_r;
        exp_dbz  <= 1'b0;
      end
    end else if (start) begin
      if (b == 0) begin
        exp_busy <= 1'b0;
        exp_done <= 1'b1;
        exp_q    <= '1;
        exp_r    <= a;
        exp_dbz  <= 1'b1;
      end else begin
        m_left   <= W;
        exp_busy <= 1'b1;
        exp_done <= 1'b0;
        pend_q   <= a / b;
        pend_r   <= a % b;
      end
    end else begin
      exp_busy <= 1'b0;
      exp_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    check("cmp_busy", busy, exp_busy);
    check("cmp_done", done, exp_done);
    check("cmp_q", q, exp_q);
    check("cmp_r", r, exp_r);
    check("cmp_dbz", div_by_zero, exp_dbz);
  end

  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Issue one op at the current negedge, scramble inputs during RUN, wait for done.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    int lat;
    int nbusy;
    start = 1'b1;
    a = av;
    b = bv;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    lat = 1;
    nbusy = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
      lat++;
    end
    check("latency", lat, (bv != 0) ? W + 1 : 1);
    check("busy_cycles", nbusy, (bv != 0) ? W : 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int ndone;
    int gap;

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", q, 0);
    check("rst_r", r, 0);
    check("rst_dbz", div_by_zero, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 13 / 3
    do_op(4'd13, 4'd3);
    check("d13_3_q", q, 4);
    check("d13_3_r", r, 1);
    check("d13_3_dbz", div_by_zero, 0);
    check("model_13_3_q", exp_q, 4);
    check("model_13_3_r", exp_r, 1);

    // 7 / 0 then 15 / 15
    @(negedge clk);
    do_op(4'd7, 4'd0);
    check("d7_0_q", q, 15);
    check("d7_0_r", r, 7);
    check("d7_0_dbz", div_by_zero, 1);
    check("model_7_0_dbz", exp_dbz, 1);
    @(negedge clk);
    check("d7_0_hold_dbz", div_by_zero, 1);
    check("d7_0_hold_q", q, 15);
    do_op(4'd15, 4'd15);
    check("d15_15_q", q, 1);
    check("d15_15_r", r, 0);
    check("d15_15_dbz", div_by_zero, 0);

    // Back-to-back with start held high
    @(negedge clk);
    start = 1'b1;
    a = 4'd15;
    b = 4'd1;
    @(negedge clk);
    a = 4'd0;
    b = 4'd5;
    wait_done(1, lat);
    check("b2b_op1_lat", lat, W + 1);
    check("b2b_op1_q", q, 15);
    check("b2b_op1_r", r, 0);
    @(negedge clk);
    start = 1'b0;
    check("b2b_no_gap_busy", busy, 1);
    wait_done(1, lat);
    check("b2b_op2_lat", lat, W + 1);
    check("b2b_op2_q", q, 0);
    check("b2b_op2_r", r, 0);

    // start and operands disturbed during RUN of 9 / 2
    @(negedge clk);
    start = 1'b1;
    a = 4'd9;
    b = 4'd2;
    @(negedge clk);
    start = 1'b0;
    a = 4'd3;
    b = 4'd1;
    @(negedge clk);
    start = 1'b1;
    a = 4'd5;
    b = 4'd0;
    @(negedge clk);
    start = 1'b0;
    a = 4'd15;
    b = 4'd15;
    wait_done(3, lat);
    check("ign_lat", lat, W + 1);
    check("ign_q", q, 4);
    check("ign_r", r, 1);
    ndone = 0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("ign_single_done", ndone, 0);

    // Asynchronous reset during RUN of 14 / 3
    start = 1'b1;
    a = 4'd14;
    b = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_q", q, 0);
    check("arst_r", r, 0);
    check("arst_dbz", div_by_zero, 0);
    check("model_arst_q", exp_q, 0);
    ndone = 0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("arst_no_done", ndone, 0);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(4'd14, 4'd3);
    check("d14_3_q", q, 4);
    check("d14_3_r", r, 2);

    // Exhaustive with random gaps (gap 0 exercises back-to-back)
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        gap = $urandom_range(0, 2);
        repeat (gap) @(negedge clk);
        do_op(W'(ai), W'(bi));
        check("ex_q", q, (bi != 0) ? ai / bi : 15);
        check("ex_r", r, (bi != 0) ? ai % bi : ai);
        check("ex_dbz", div_by_zero, (bi == 0) ? 1 : 0);
      end
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
